// File: rtl/fetch_pc_pkg.sv
// Shared definitions for the fetch/PC front end: FSM state encodings,
// instruction field positions and the default reset PC.
package fetch_pc_pkg;

   typedef enum logic [1:0] {
      S_RESET = 2'd0,
      S_FETCH = 2'd1,
      S_ISSUE = 2'd2,
      S_HALT  = 2'd3
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   localparam int OPC_MSB  = 31;
   localparam int OPC_LSB  = 26;
   localparam int RS_MSB   = 25;
   localparam int RS_LSB   = 21;
   localparam int RT_MSB   = 20;
   localparam int RT_LSB   = 16;
   localparam int RD_MSB   = 15;
   localparam int RD_LSB   = 11;
   localparam int FUNC_MSB = 5;
   localparam int FUNC_LSB = 0;
   localparam int IMM_MSB  = 15;
   localparam int IMM_LSB  = 0;
   localparam int JIDX_MSB = 25;

endpackage

// File: rtl/fetch_pc_unit_next_pc_calc.sv
// Combinational next-PC selection: jump > taken BEQ > taken BNE > pc+4.
// All additions wrap modulo 2^ADDR_W.
module next_pc_calc
   import fetch_pc_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic [JIDX_MSB:0] ir_idx,
   input  logic              is_jmp,
   input  logic              is_beq,
   input  logic              is_bne,
   input  logic              alu_zero,
   output logic [ADDR_W-1:0] next_pc,
   output logic              taken
);

   logic [IMM_MSB:0]  imm16;
   logic [ADDR_W-1:0] pc4;
   logic [ADDR_W-1:0] br_off;
   logic [ADDR_W-1:0] br_tgt;
   logic [ADDR_W-1:0] jmp_tgt;

   always_comb begin
      imm16   = ir_idx[IMM_MSB:IMM_LSB];
      pc4     = pc + ADDR_W'(4);
      br_off  = {{(ADDR_W-18){imm16[IMM_MSB]}}, imm16, 2'b00};
      br_tgt  = pc4 + br_off;
      jmp_tgt = {pc4[ADDR_W-1:28], ir_idx, 2'b00};
      next_pc = pc4;
      taken   = 1'b0;
      if (is_jmp) begin
         next_pc = jmp_tgt;
         taken   = 1'b1;
      end else if ((is_beq && alu_zero) || (is_bne && !alu_zero)) begin
         next_pc = br_tgt;
         taken   = 1'b1;
      end
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC holder and instruction fetch FSM feeding the single-cycle decoder.
// Optional retired/taken counters are enabled with FETCH_PERF_CNT_EN.
//
// state   | meaning
// S_RESET | one idle cycle after reset release
// S_FETCH | imem_req high at pc, waiting for imem_ack
// S_ISSUE | ir presented to decoder, waiting for exec_done
// S_HALT  | invalid opcode seen, frozen until reset
module fetch_pc_unit
   import fetch_pc_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic              instr_valid,
   output logic [5:0]        opc,
   output logic [5:0]        func,
   output logic [4:0]        rs,
   output logic [4:0]        rt,
   output logic [4:0]        rd,
   output logic [15:0]       imm16,
   output logic [ADDR_W-1:0] pc_out,
   input  logic              isJmp,
   input  logic              isBeq,
   input  logic              isBne,
   input  logic              invOpcode,
   input  logic              alu_zero,
   input  logic              exec_done,
   output logic              halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       retired_cnt,
   output logic [31:0]       taken_cnt
`endif
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;
   logic [ADDR_W-1:0] next_pc;
   logic              br_taken;
   logic              retire;

   next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc_calc (
      .pc       (pc_q),
      .ir_idx   (ir_q[JIDX_MSB:0]),
      .is_jmp   (isJmp),
      .is_beq   (isBeq),
      .is_bne   (isBne),
      .alu_zero (alu_zero),
      .next_pc  (next_pc),
      .taken    (br_taken)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      retire  = 1'b0;
      case (state_q)
         S_RESET: state_d = S_FETCH;
         S_FETCH: begin
            if (imem_ack) begin
               ir_d    = imem_rdata;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (exec_done) begin
               if (invOpcode) begin
                  state_d = S_HALT;
               end else begin
                  pc_d    = next_pc;
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
            end
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_RESET;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_RESET;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   // Handshake outputs decode straight from the state flop so reset drops them asynchronously.
   assign imem_req    = (state_q == S_FETCH);
   assign imem_addr   = pc_q;
   assign instr_valid = (state_q == S_ISSUE);
   assign halted      = (state_q == S_HALT);
   assign pc_out      = pc_q;
   assign opc         = ir_q[OPC_MSB:OPC_LSB];
   assign func        = ir_q[FUNC_MSB:FUNC_LSB];
   assign rs          = ir_q[RS_MSB:RS_LSB];
   assign rt          = ir_q[RT_MSB:RT_LSB];
   assign rd          = ir_q[RD_MSB:RD_LSB];
   assign imm16       = ir_q[IMM_MSB:IMM_LSB];

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] retired_q, retired_d;
   logic [31:0] taken_q, taken_d;

   always_comb begin
      retired_d = retired_q;
      taken_d   = taken_q;
      if (retire) begin
         retired_d = retired_q + 32'd1;
         if (br_taken) taken_d = taken_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_q <= '0;
         taken_q   <= '0;
      end else begin
         retired_q <= retired_d;
         taken_q   <= taken_d;
      end
   end

   assign retired_cnt = retired_q;
   assign taken_cnt   = taken_q;
`else
   logic unused_perf;
   assign unused_perf = br_taken & retire;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit; a second instance with a
// high RESET_PC exercises jumps that keep the upper PC nibble.
module tb_fetch_pc_unit;

   logic        clk, rst_n, rst_hi_n;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        isJmp, isBeq, isBne, invOpcode, alu_zero, exec_done;

   logic        imem_req, instr_valid, halted;
   logic [31:0] imem_addr, pc_out;
   logic [5:0]  opc, func;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm16;

   logic        imem_req_h, instr_valid_h, halted_h;
   logic [31:0] imem_addr_h, pc_out_h;
   logic [5:0]  opc_h, func_h;
   logic [4:0]  rs_h, rt_h, rd_h;
   logic [15:0] imm16_h;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] retired_cnt, taken_cnt, retired_cnt_h, taken_cnt_h;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   fetch_pc_unit u_dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .opc(opc), .func(func), .rs(rs), .rt(rt), .rd(rd),
      .imm16(imm16), .pc_out(pc_out),
      .isJmp(isJmp), .isBeq(isBeq), .isBne(isBne), .invOpcode(invOpcode),
      .alu_zero(alu_zero), .exec_done(exec_done), .halted(halted)
`ifdef FETCH_PERF_CNT_EN
      , .retired_cnt(retired_cnt), .taken_cnt(taken_cnt)
`endif
   );

   fetch_pc_unit #(.RESET_PC(32'h3000_0000)) u_dut_hi (
      .clk(clk), .rst_n(rst_hi_n),
      .imem_req(imem_req_h), .imem_addr(imem_addr_h), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid_h), .opc(opc_h), .func(func_h), .rs(rs_h), .rt(rt_h), .rd(rd_h),
      .imm16(imm16_h), .pc_out(pc_out_h),
      .isJmp(isJmp), .isBeq(isBeq), .isBne(isBne), .invOpcode(invOpcode),
      .alu_zero(alu_zero), .exec_done(exec_done), .halted(halted_h)
`ifdef FETCH_PERF_CNT_EN
      , .retired_cnt(retired_cnt_h), .taken_cnt(taken_cnt_h)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      isJmp      = 1'b0;
      isBeq      = 1'b0;
      isBne      = 1'b0;
      invOpcode  = 1'b0;
      alu_zero   = 1'b0;
      exec_done  = 1'b0;
   endtask

   // Called in S_FETCH at pc; leaves the DUT in S_FETCH at the expected next pc.
   task automatic run_instr(input string tag, input logic [31:0] pc, input logic [31:0] word,
                            input logic j, input logic b, input logic n, input logic z,
                            input int ack_dly, input int done_dly, input logic [31:0] exp_next);
      for (int i = 0; i < ack_dly; i++) begin
         chk({tag, ":req_wait"}, 32'(imem_req), 32'd1);
         chk({tag, ":addr_wait"}, imem_addr, pc);
         tick();
      end
      chk({tag, ":req"}, 32'(imem_req), 32'd1);
      chk({tag, ":addr"}, imem_addr, pc);
      imem_ack   = 1'b1;
      imem_rdata = word;
      tick();
      clear_inputs();
      chk({tag, ":valid"}, 32'(instr_valid), 32'd1);
      chk({tag, ":req_issue"}, 32'(imem_req), 32'd0);
      chk({tag, ":pc_out"}, pc_out, pc);
      chk({tag, ":opc"}, 32'(opc), 32'(word[31:26]));
      chk({tag, ":func"}, 32'(func), 32'(word[5:0]));
      chk({tag, ":rs_rt_rd"}, {17'h0, rs, rt, rd}, {17'h0, word[25:11]});
      chk({tag, ":imm16"}, 32'(imm16), 32'(word[15:0]));
      for (int i = 0; i < done_dly; i++) begin
         // flags and a stray ack without exec_done must not disturb the issued instruction
         isJmp = 1'b1; isBeq = 1'b1; invOpcode = 1'b1; imem_ack = 1'b1; imem_rdata = ~word;
         tick();
         chk({tag, ":hold_valid"}, 32'(instr_valid), 32'd1);
         chk({tag, ":hold_pc"}, pc_out, pc);
         chk({tag, ":hold_ir"}, {opc, 10'h0, imm16}, {word[31:26], 10'h0, word[15:0]});
         chk({tag, ":hold_req"}, 32'(imem_req), 32'd0);
      end
      clear_inputs();
      isJmp = j; isBeq = b; isBne = n; alu_zero = z; exec_done = 1'b1;
      tick();
      clear_inputs();
      chk({tag, ":next_req"}, 32'(imem_req), 32'd1);
      chk({tag, ":next_addr"}, imem_addr, exp_next);
      chk({tag, ":next_valid"}, 32'(instr_valid), 32'd0);
   endtask

   initial begin
      rst_n    = 1'b0;
      rst_hi_n = 1'b0;
      clear_inputs();
      #3;
      chk("rst:req", 32'(imem_req), 32'd0);
      chk("rst:valid", 32'(instr_valid), 32'd0);
      chk("rst:halted", 32'(halted), 32'd0);
      chk("rst:pc_out", pc_out, 32'h0);
      chk("rst:fields", {opc, func, imm16, 4'h0}, 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      chk("rel:req_idle", 32'(imem_req), 32'd0);
      tick();

      run_instr("and",      32'h00, 32'h0000_0024, 0, 0, 0, 0, 0, 0, 32'h04);
      run_instr("j_10",     32'h04, 32'h0800_0004, 1, 0, 0, 0, 0, 0, 32'h10);
      run_instr("beq_t",    32'h10, 32'h1000_FFFC, 0, 1, 0, 1, 3, 0, 32'h04);
      run_instr("j_10b",    32'h04, 32'h0800_0004, 1, 0, 0, 0, 0, 0, 32'h10);
      run_instr("beq_nt",   32'h10, 32'h1000_FFFC, 0, 1, 0, 0, 0, 5, 32'h14);
      run_instr("j_20",     32'h14, 32'h0800_0008, 1, 0, 0, 0, 0, 0, 32'h20);
      run_instr("bne_t",    32'h20, 32'h1400_0003, 0, 0, 1, 0, 0, 0, 32'h30);
      run_instr("beq_bne",  32'h30, 32'h1000_0001, 0, 1, 1, 1, 0, 0, 32'h38);

      chk("halt:req", 32'(imem_req), 32'd1);
      imem_ack = 1'b1; imem_rdata = 32'hFC00_0000;
      tick();
      clear_inputs();
      chk("halt:valid", 32'(instr_valid), 32'd1);
      invOpcode = 1'b1; exec_done = 1'b1; isJmp = 1'b1;
      tick();
      chk("halt:halted", 32'(halted), 32'd1);
      chk("halt:valid_lo", 32'(instr_valid), 32'd0);
      chk("halt:pc_kept", imem_addr, 32'h38);
      imem_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("halt:no_req", 32'(imem_req), 32'd0);
         chk("halt:stays", 32'(halted), 32'd1);
      end
      clear_inputs();

      rst_hi_n = 1'b1;
      tick();
      chk("hi:req", 32'(imem_req_h), 32'd1);
      chk("hi:addr", imem_addr_h, 32'h3000_0000);
      imem_ack = 1'b1; imem_rdata = 32'h0800_0100;
      tick();
      clear_inputs();
      chk("hi:valid", 32'(instr_valid_h), 32'd1);
      isJmp = 1'b1; exec_done = 1'b1;
      tick();
      clear_inputs();
      chk("hi:j_addr", imem_addr_h, 32'h3000_0400);
      chk("hi:j_req", 32'(imem_req_h), 32'd1);
      chk("hi:main_halted", 32'(halted), 32'd1);
      rst_hi_n = 1'b0;

      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rst2:halted", 32'(halted), 32'd0);
      tick();
      run_instr("and2", 32'h00, 32'h0000_0024, 0, 0, 0, 0, 0, 0, 32'h04);
      imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
      tick();
      clear_inputs();
      chk("mid:valid", 32'(instr_valid), 32'd1);
      chk("mid:pc_out", pc_out, 32'h04);
      chk("mid:opc", 32'(opc), 32'h04);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid:valid_clr", 32'(instr_valid), 32'd0);
      chk("mid:req_clr", 32'(imem_req), 32'd0);
      chk("mid:pc_clr", pc_out, 32'h0);
      chk("mid:fields_clr", {opc, func, imm16, 4'h0}, 32'h0);
      chk("mid:regs_clr", {17'h0, rs, rt, rd}, 32'h0);
      tick();
      rst_n = 1'b1;
      chk("mid:rel_idle", 32'(imem_req), 32'd0);
      tick();
      chk("mid:restart_req", 32'(imem_req), 32'd1);
      chk("mid:restart_addr", imem_addr, 32'h0);

`ifdef FETCH_PERF_CNT_EN
      chk("cnt:retired0", retired_cnt, 32'd0);
      chk("cnt:taken0", taken_cnt, 32'd0);
      run_instr("c_and",    32'h00, 32'h0000_0024, 0, 0, 0, 0, 0, 0, 32'h04);
      run_instr("c_beq_t",  32'h04, 32'h1000_FFFF, 0, 1, 0, 1, 0, 0, 32'h04);
      run_instr("c_beq_nt", 32'h04, 32'h1000_FFFF, 0, 1, 0, 0, 0, 0, 32'h08);
      run_instr("c_j",      32'h08, 32'h0800_0000, 1, 0, 0, 0, 0, 0, 32'h00);
      chk("cnt:retired", retired_cnt, 32'd4);
      chk("cnt:taken", taken_cnt, 32'd2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
